audio_chan_mixer: RTL and testbench
===================================

AUDIO_CHAN_MIXER -- requirements
Module: audio_chan_mixer

Interface
REQ-001 SHALL have parameter NCH, default 4, number of input channels (1..8).
REQ-002 SHALL have parameter IW, default 14, input sample width per channel (8..16).
REQ-003 SHALL have parameter OW, default 16, output sample width (OW >= IW).
REQ-004 SHALL have port clk_sys  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port ce_sample  input  1  one-cycle strobe starting a mix.
REQ-007 SHALL have port ch_data  input  NCH*IW  channel samples; channel k at bits [k*IW +: IW].
REQ-008 SHALL have port ch_signed  input  NCH  1 = channel two's complement, 0 = unsigned offset-binary.
REQ-009 SHALL have port ch_en  input  NCH  per-channel enable.
REQ-010 SHALL have port ch_atten  input  NCH*3  per-channel arithmetic right-shift amount, 0..7.
REQ-011 SHALL have port clip_clr  input  1  clears the clip and overrun flags.
REQ-012 SHALL have port out_data  output  OW  signed mixed sample.
REQ-013 SHALL have port out_valid  output  1  one-cycle pulse when out_data updates.
REQ-014 SHALL have port clip  output  1  sticky saturation flag.
REQ-015 SHALL have port overrun  output  1  sticky flag for a strobe received while busy.

Function
REQ-016 SHALL implement FSM IDLE -> ACC -> DONE -> IDLE.
REQ-017 In IDLE, ce_sample SHALL snapshot ch_data, ch_signed, ch_en and ch_atten, clear the accumulator, and enter ACC. Later input changes SHALL NOT affect that mix.
REQ-018 ACC SHALL process one channel per cycle, in order 0..NCH-1, and then enter DONE.
REQ-019 Unsigned channels SHALL be converted to signed by inverting the MSB. Signed channels SHALL be used as is.
REQ-020 Each converted sample SHALL be sign-extended to accumulator width IW+4, arithmetic-shifted right by its ch_atten value, and added only if its ch_en bit is set.
REQ-021 DONE SHALL saturate the accumulator to the signed IW range [-2^(IW-1), 2^(IW-1)-1].
REQ-022 DONE SHALL left-justify the saturated value into out_data, zero-filling the low OW-IW bits, and assert out_valid.
REQ-023 Latency: out_valid SHALL be high in exactly one cycle, NCH+1 edges after the edge that sampled ce_sample.
REQ-024 out_data SHALL hold its value between updates.
REQ-025 Saturation in DONE SHALL set clip.
REQ-026 ce_sample received in ACC or DONE SHALL be ignored and SHALL set overrun. The running mix SHALL complete unaffected.
REQ-027 clip_clr SHALL clear clip and overrun. If a set and clip_clr occur in the same cycle, the set SHALL win.
REQ-028 ce_sample asserted in the same cycle as out_valid SHALL count as busy (overrun). Minimum strobe spacing is NCH+2 cycles.
REQ-029 With all channels disabled, out_data SHALL be 0.

Reset
REQ-030 reset_n low SHALL asynchronously force: FSM = IDLE, accumulator = 0, snapshot = 0, out_data = 0, out_valid = 0, clip = 0, overrun = 0.
REQ-031 Reset during ACC or DONE SHALL abort the mix with no out_valid pulse. The first ce_sample after release SHALL start a fresh mix.
REQ-032 Reset release SHALL be sampled synchronously. No ce_sample SHALL be acted on in the release cycle.

Verification (NCH=4, IW=14, OW=16)
REQ-033 ch_en=0000, ce_sample -> out_valid exactly 5 edges later, out_data=16'h0000, clip=0.
REQ-034 ch0 unsigned 14'h3FFF, en=0001, atten=0 -> out_data=16'h7FFC, clip=0.
REQ-035 All four channels unsigned 14'h3FFF, en=1111, atten=0 -> sum 32764 saturates to 8191, out_data=16'h7FFC, clip=1. clip stays 1 until clip_clr, then reads 0.
REQ-036 ch0 signed 14'h2000 (-8192), atten=1, en=0001 -> out_data=16'hC000. Second pass with ch1 unsigned 14'h0000 (-8192), both enabled, atten=0 -> saturates to -8192, out_data=16'h8000, clip=1.
REQ-037 ce_sample at edge 0 and again at edge 2 -> single out_valid at edge 5, overrun=1. ch_data changed at edge 1 does not alter out_data.
REQ-038 reset_n low at edge 3 of a mix -> out_valid never pulses for that mix, out_data=0, flags=0. A new ce_sample after release gives correct output.

Source files
------------

// File: rtl/audio_chan_mixer.sv
// Sequential N-channel audio mixer: snapshots all channels on a strobe, accumulates
// one channel per cycle, then saturates and left-justifies the result into out_data.
module audio_chan_mixer #(
    parameter int NCH = 4,
    parameter int IW  = 14,
    parameter int OW  = 16
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ce_sample,
    input  logic [NCH*IW-1:0]   ch_data,
    input  logic [NCH-1:0]      ch_signed,
    input  logic [NCH-1:0]      ch_en,
    input  logic [NCH*3-1:0]    ch_atten,
    input  logic                clip_clr,
    output logic [OW-1:0]       out_data,
    output logic                out_valid,
    output logic                clip,
    output logic                overrun
);

    localparam int AW = IW + 4;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic signed [AW-1:0] SAT_MAX = {5'b00000, {(IW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {5'b11111, {(IW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                 state, state_nx;
    logic                   armed;
    logic [CW-1:0]          idx;
    logic signed [AW-1:0]   acc;

    logic [NCH*IW-1:0]      snap_data;
    logic [NCH-1:0]         snap_signed;
    logic [NCH-1:0]         snap_en;
    logic [NCH*3-1:0]       snap_atten;

    logic                   accept, busy, last_ch;
    logic [IW-1:0]          raw, conv, sat_val;
    logic signed [AW-1:0]   ext, shifted;
    logic                   sat_hi, sat_lo;
    logic [OW-1:0]          just;

    // armed lags reset release by one edge so a strobe in the release cycle is ignored
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) armed <= 1'b0;
        else          armed <= 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = ACC;
            ACC:     if (last_ch) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The out_valid cycle still counts as busy, so a strobe landing there is an overrun
    always_comb begin
        busy    = (state != IDLE) || out_valid;
        accept  = (state == IDLE) && ce_sample && armed && !out_valid;
        last_ch = (idx == CW'(NCH - 1));
    end

    always_comb begin
        raw     = snap_data[idx*IW +: IW];
        conv    = snap_signed[idx] ? raw : {~raw[IW-1], raw[IW-2:0]};
        ext     = {{4{conv[IW-1]}}, conv};
        shifted = ext >>> snap_atten[idx*3 +: 3];
    end

    always_comb begin
        sat_hi = (acc > SAT_MAX);
        sat_lo = (acc < SAT_MIN);
        if (sat_hi)      sat_val = {1'b0, {(IW-1){1'b1}}};
        else if (sat_lo) sat_val = {1'b1, {(IW-1){1'b0}}};
        else             sat_val = acc[IW-1:0];
        just = '0;
        just[OW-1 -: IW] = sat_val;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            idx         <= '0;
            acc         <= '0;
            snap_data   <= '0;
            snap_signed <= '0;
            snap_en     <= '0;
            snap_atten  <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                snap_data   <= ch_data;
                snap_signed <= ch_signed;
                snap_en     <= ch_en;
                snap_atten  <= ch_atten;
                acc         <= '0;
                idx         <= '0;
            end
            if (state == ACC) begin
                if (snap_en[idx]) acc <= acc + shifted;
                idx <= last_ch ? '0 : idx + 1'b1;
            end
            if (state == DONE) begin
                out_data  <= just;
                out_valid <= 1'b1;
            end
        end
    end

    // A set in the same cycle as clip_clr takes priority
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clip    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if ((state == DONE) && (sat_hi || sat_lo)) clip <= 1'b1;
            else if (clip_clr)                        clip <= 1'b0;
            if (ce_sample && busy)                     overrun <= 1'b1;
            else if (clip_clr)                        overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_chan_mixer.sv
// Directed self-checking bench for audio_chan_mixer (NCH=4, IW=14, OW=16).
module tb_audio_chan_mixer;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ce_sample;
    logic [55:0] ch_data;
    logic [3:0]  ch_signed;
    logic [3:0]  ch_en;
    logic [11:0] ch_atten;
    logic        clip_clr;
    logic [15:0] out_data;
    logic        out_valid;
    logic        clip;
    logic        overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    audio_chan_mixer #(.NCH(4), .IW(14), .OW(16)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce_sample (ce_sample),
        .ch_data   (ch_data),
        .ch_signed (ch_signed),
        .ch_en     (ch_en),
        .ch_atten  (ch_atten),
        .clip_clr  (clip_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .clip      (clip),
        .overrun   (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk_sys);
        #1;
    endtask

    // Strobe one mix and check the valid pulse lands 5 edges after the sampling edge
    task automatic mix(input string tag, input logic [55:0] d, input logic [3:0] sg,
                       input logic [3:0] en, input logic [11:0] at);
        int lat = 0;
        ch_data   = d;
        ch_signed = sg;
        ch_en     = en;
        ch_atten  = at;
        ce_sample = 1'b1;
        edge_step();
        ce_sample = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            edge_step();
            if (out_valid) lat = k;
        end
        check({tag, "_lat"}, lat, 5);
        edge_step();
        check({tag, "_pulse"}, {31'd0, out_valid}, 0);
    endtask

    initial begin
        int pulses;
        int vat;

        reset_n   = 1'b0;
        ce_sample = 1'b0;
        clip_clr  = 1'b0;
        ch_data   = '0;
        ch_signed = '0;
        ch_en     = '0;
        ch_atten  = '0;
        #2;
        check("rst_data",    out_data, 0);
        check("rst_valid",   {31'd0, out_valid}, 0);
        check("rst_clip",    {31'd0, clip}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);

        // Strobe coincident with release must be ignored
        edge_step();
        edge_step();
        reset_n   = 1'b1;
        ce_sample = 1'b1;
        ch_en     = 4'b0001;
        ch_data   = {14'h0, 14'h0, 14'h0, 14'h3FFF};
        edge_step();
        ce_sample = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            edge_step();
            if (out_valid) pulses++;
        end
        check("release_no_mix", pulses, 0);
        check("release_overrun", {31'd0, overrun}, 0);

        mix("all_off", {4{14'h3FFF}}, 4'b0000, 4'b0000, 12'h000);
        check("all_off_data", out_data, 32'h0000);
        check("all_off_clip", {31'd0, clip}, 0);

        mix("ch0_max", {14'h0, 14'h0, 14'h0, 14'h3FFF}, 4'b0000, 4'b0001, 12'h000);
        check("ch0_max_data", out_data, 32'h7FFC);
        check("ch0_max_clip", {31'd0, clip}, 0);

        mix("sat_pos", {4{14'h3FFF}}, 4'b0000, 4'b1111, 12'h000);
        check("sat_pos_data", out_data, 32'h7FFC);
        check("sat_pos_clip", {31'd0, clip}, 1);
        edge_step();
        edge_step();
        check("clip_sticky", {31'd0, clip}, 1);
        clip_clr = 1'b1;
        edge_step();
        clip_clr = 1'b0;
        check("clip_cleared", {31'd0, clip}, 0);

        mix("neg_att", {14'h0, 14'h0, 14'h0, 14'h2000}, 4'b0001, 4'b0001, 12'o0001);
        check("neg_att_data", out_data, 32'hC000);
        check("neg_att_clip", {31'd0, clip}, 0);

        mix("sat_neg", {14'h0, 14'h0, 14'h0000, 14'h2000}, 4'b0001, 4'b0011, 12'h000);
        check("sat_neg_data", out_data, 32'h8000);
        check("sat_neg_clip", {31'd0, clip}, 1);
        clip_clr = 1'b1;
        edge_step();
        clip_clr = 1'b0;

        // 4096>>>3 = 512, -8192>>>7 = -64, ch0 offset-binary midpoint = 0, ch1 disabled
        mix("mixed", {14'h0000, 14'h1000, 14'h3FFF, 14'h2000}, 4'b0100, 4'b1101, 12'o7300);
        check("mixed_data", out_data, 32'h0700);
        check("mixed_clip", {31'd0, clip}, 0);

        // Second strobe during ACC, data change after snapshot
        ch_data   = {14'h0, 14'h0, 14'h0, 14'h0123};
        ch_signed = 4'b0001;
        ch_en     = 4'b0001;
        ch_atten  = 12'h000;
        ce_sample = 1'b1;
        edge_step();
        ce_sample = 1'b0;
        ch_data   = {4{14'h3FFF}};
        edge_step();
        ce_sample = 1'b1;
        edge_step();
        ce_sample = 1'b0;
        pulses = 0;
        vat    = 0;
        for (int k = 3; k <= 12; k++) begin
            edge_step();
            if (out_valid) begin
                pulses++;
                if (vat == 0) vat = k;
            end
        end
        check("ovr_pulses", pulses, 1);
        check("ovr_lat", vat, 5);
        check("ovr_data", out_data, 32'h048C);
        check("ovr_flag", {31'd0, overrun}, 1);
        clip_clr = 1'b1;
        edge_step();
        clip_clr = 1'b0;
        check("ovr_cleared", {31'd0, overrun}, 0);

        // Strobe in the out_valid cycle is an overrun and wins over a same-cycle clear
        ch_data   = {14'h0, 14'h0, 14'h0, 14'h0123};
        ce_sample = 1'b1;
        edge_step();
        ce_sample = 1'b0;
        vat = 0;
        for (int k = 1; k <= 20 && vat == 0; k++) begin
            edge_step();
            if (out_valid) vat = k;
        end
        check("busy_lat", vat, 5);
        ce_sample = 1'b1;
        clip_clr  = 1'b1;
        edge_step();
        ce_sample = 1'b0;
        clip_clr  = 1'b0;
        check("busy_ovr", {31'd0, overrun}, 1);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            edge_step();
            if (out_valid) pulses++;
        end
        check("busy_no_mix", pulses, 0);

        // Reset in the middle of a mix
        ch_data   = {14'h0, 14'h0, 14'h0, 14'h1000};
        ce_sample = 1'b1;
        edge_step();
        ce_sample = 1'b0;
        edge_step();
        edge_step();
        edge_step();
        reset_n = 1'b0;
        #1;
        check("abort_data", out_data, 0);
        check("abort_ovr",  {31'd0, overrun}, 0);
        check("abort_clip", {31'd0, clip}, 0);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            edge_step();
            if (out_valid) pulses++;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            edge_step();
            if (out_valid) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        check("abort_data_hold", out_data, 0);

        // 291 + (-1) = 290 -> 0x122 << 2
        mix("post_rst", {14'h0, 14'h0, 14'h3FFF, 14'h0123}, 4'b0011, 4'b0011, 12'h000);
        check("post_rst_data", out_data, 32'h0488);
        check("post_rst_clip", {31'd0, clip}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
